// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use/branch hazard stalls and mult/div EX sequencing
// for the 5-stage core.
module hazard_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeRegAddrE,
    input  logic [4:0] writeRegAddrM,
    input  logic [4:0] writeRegAddrW,
    input  logic       regWriteE,
    input  logic       regWriteM,
    input  logic       regWriteW,
    input  logic       memToRegE,
    input  logic       memToRegM,
    input  logic       branchD,
    input  logic       branchTakenD,
    input  logic       mdStartE,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       mdBusy,
    output logic       mdDone
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_t;

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             md_stall;
    logic             lw_stall;
    logic             br_stall;
    logic             hz_stall;

    // A writer only matches when it writes a nonzero register equal to r.
    function automatic logic hit(input logic we, input logic [4:0] wa, input logic [4:0] r);
        return we && wa != 5'd0 && wa == r;
    endfunction

    always_comb begin
        forwardAE = hit(regWriteM, writeRegAddrM, rsE) ? 2'b01 :
                    hit(regWriteW, writeRegAddrW, rsE) ? 2'b10 : 2'b00;
        forwardBE = hit(regWriteM, writeRegAddrM, rtE) ? 2'b01 :
                    hit(regWriteW, writeRegAddrW, rtE) ? 2'b10 : 2'b00;
        forwardAD = hit(regWriteM, writeRegAddrM, rsD);
        forwardBD = hit(regWriteM, writeRegAddrM, rtD);
        lw_stall  = memToRegE && (hit(regWriteE, writeRegAddrE, rsD) || hit(regWriteE, writeRegAddrE, rtD));
        br_stall  = branchD && (hit(regWriteE, writeRegAddrE, rsD) || hit(regWriteE, writeRegAddrE, rtD) ||
                                hit(memToRegM, writeRegAddrM, rsD) || hit(memToRegM, writeRegAddrM, rtD));
        hz_stall  = lw_stall || br_stall;
        // Gated by rst so a held mdStartE cannot re-raise the stall while reset is asserted.
        md_stall  = !rst && ((state == IDLE && mdStartE) || state == RUN);
        mdBusy    = md_stall;
        mdDone    = state == DONE;
        stallF    = md_stall || hz_stall;
        stallD    = md_stall || hz_stall;
        stallE    = md_stall;
        flushM    = md_stall;
        flushE    = !md_stall && hz_stall;
        flushD    = !md_stall && !hz_stall && branchTakenD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state == IDLE ? (mdStartE ? RUN : IDLE) :
                     state == RUN  ? (cnt == CNT_W'(1) ? DONE : RUN) : IDLE;
            cnt   <= (state == IDLE && mdStartE) ? CNT_W'(MD_LATENCY - 1) :
                     state == RUN ? cnt - CNT_W'(1) : cnt;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of forwarding, hazard stalls and the mult/div sequencer
// (built with MD_LATENCY=4).
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeRegAddrE, writeRegAddrM, writeRegAddrW;
    logic       regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
    logic       branchD, branchTakenD, mdStartE;
    logic [1:0] forwardAE, forwardBE;
    logic       forwardAD, forwardBD, stallF, stallD, stallE, flushD, flushE, flushM, mdBusy, mdDone;
    logic [5:0] ctl;
    int         tests = 0;
    int         fails = 0;

    assign ctl = {stallF, stallD, stallE, flushD, flushE, flushM};

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LATENCY(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeRegAddrE(writeRegAddrE), .writeRegAddrM(writeRegAddrM), .writeRegAddrW(writeRegAddrW),
        .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .memToRegE(memToRegE), .memToRegM(memToRegM), .branchD(branchD),
        .branchTakenD(branchTakenD), .mdStartE(mdStartE),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .forwardAD(forwardAD), .forwardBD(forwardBD),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushD(flushD), .flushE(flushE),
        .flushM(flushM), .mdBusy(mdBusy), .mdDone(mdDone)
    );

    task automatic clr;
        {rsD, rtD, rsE, rtE, writeRegAddrE, writeRegAddrM, writeRegAddrW} = '0;
        {regWriteE, regWriteM, regWriteW, memToRegE, memToRegM} = '0;
        {branchD, branchTakenD, mdStartE} = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clr();
        #1;
        tests++;
        if ({ctl, mdBusy, mdDone, forwardAE, forwardBE} !== 12'h0) begin
            fails++;
            $display("FAIL reset_state got %b want 0", {ctl, mdBusy, mdDone, forwardAE, forwardBE});
        end
        regWriteM = 1'b1; writeRegAddrM = 5'd5; rsE = 5'd5;
        #1;
        tests++;
        if (forwardAE !== 2'b01) begin
            fails++;
            $display("FAIL reset_comb_fwd got %b want 01", forwardAE);
        end
        clr();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_forward;
        clr();
        regWriteM = 1'b1; writeRegAddrM = 5'd5; regWriteW = 1'b1; writeRegAddrW = 5'd5;
        rsE = 5'd5; rtE = 5'd5;
        #1;
        tests++;
        if ({forwardAE, forwardBE} !== 4'b0101) begin
            fails++;
            $display("FAIL fwd_m_priority got %b want 0101", {forwardAE, forwardBE});
        end
        regWriteM = 1'b0;
        #1;
        tests++;
        if ({forwardAE, forwardBE} !== 4'b1010) begin
            fails++;
            $display("FAIL fwd_w got %b want 1010", {forwardAE, forwardBE});
        end
        regWriteM = 1'b1;
        {rsE, rtE, writeRegAddrM, writeRegAddrW} = '0;
        #1;
        tests++;
        if ({forwardAE, forwardBE} !== 4'b0000) begin
            fails++;
            $display("FAIL fwd_reg0 got %b want 0000", {forwardAE, forwardBE});
        end
        rsD = 5'd7; rtD = 5'd9; writeRegAddrM = 5'd9; rsE = 5'd2; rtE = 5'd9;
        #1;
        tests++;
        if ({forwardAD, forwardBD, forwardAE, forwardBE} !== 6'b010001) begin
            fails++;
            $display("FAIL fwd_decode got %b want 010001", {forwardAD, forwardBD, forwardAE, forwardBE});
        end
    endtask

    task automatic test_load_use;
        clr();
        memToRegE = 1'b1; regWriteE = 1'b1; writeRegAddrE = 5'd8; rtD = 5'd8;
        #1;
        tests++;
        if (ctl !== 6'b110010) begin
            fails++;
            $display("FAIL lw_stall got %b want 110010", ctl);
        end
        writeRegAddrE = 5'd0;
        #1;
        tests++;
        if (ctl !== 6'b000000) begin
            fails++;
            $display("FAIL lw_reg0 got %b want 000000", ctl);
        end
        writeRegAddrE = 5'd8; regWriteE = 1'b0;
        #1;
        tests++;
        if (ctl !== 6'b000000) begin
            fails++;
            $display("FAIL lw_no_regwrite got %b want 000000", ctl);
        end
    endtask

    task automatic test_branch;
        clr();
        branchD = 1'b1; rsD = 5'd3; memToRegM = 1'b1; writeRegAddrM = 5'd3;
        #1;
        tests++;
        if (ctl !== 6'b110010) begin
            fails++;
            $display("FAIL br_load_m got %b want 110010", ctl);
        end
        branchTakenD = 1'b1;
        #1;
        tests++;
        if ({ctl, forwardAD} !== 7'b1100100) begin
            fails++;
            $display("FAIL br_taken_stalled got %b want 1100100", {ctl, forwardAD});
        end
        memToRegM = 1'b0; regWriteM = 1'b1;
        #1;
        tests++;
        if ({ctl, forwardAD} !== 7'b0001001) begin
            fails++;
            $display("FAIL br_forward got %b want 0001001", {ctl, forwardAD});
        end
        regWriteE = 1'b1; writeRegAddrE = 5'd3;
        #1;
        tests++;
        if (ctl !== 6'b110010) begin
            fails++;
            $display("FAIL br_ex_producer got %b want 110010", ctl);
        end
    endtask

    task automatic test_md;
        int n = 0;
        clr();
        @(posedge clk);
        #1 mdStartE = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (mdDone) break;
            tests++;
            if ({ctl, mdBusy} !== 7'b1110011) begin
                fails++;
                $display("FAIL md_stall_cycle%0d got %b want 1110011", n, {ctl, mdBusy});
            end
            n++;
            @(posedge clk);
            #1;
        end
        tests++;
        if (n !== 4) begin
            fails++;
            $display("FAIL md_stall_count got %0d want 4", n);
        end
        tests++;
        if ({ctl, mdBusy, mdDone} !== 8'b00000001) begin
            fails++;
            $display("FAIL md_done got %b want 00000001", {ctl, mdBusy, mdDone});
        end
        @(posedge clk);
        #2;
        tests++;
        if ({mdBusy, mdDone, stallE} !== 3'b101) begin
            fails++;
            $display("FAIL md_back_to_back got %b want 101", {mdBusy, mdDone, stallE});
        end
        @(posedge clk);
        #1 memToRegE = 1'b1; regWriteE = 1'b1; writeRegAddrE = 5'd8; rtD = 5'd8;
        #1;
        tests++;
        if (ctl !== 6'b111001) begin
            fails++;
            $display("FAIL md_masks_lw got %b want 111001", ctl);
        end
        memToRegE = 1'b0; regWriteE = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            if (mdDone) break;
            n++;
        end
        tests++;
        if ({mdDone, n} !== {1'b1, 32'd2}) begin
            fails++;
            $display("FAIL md_second_done got done=%b extra=%0d want done=1 extra=2", mdDone, n);
        end
        mdStartE = 1'b0;
        @(posedge clk);
        #2;
        tests++;
        if ({mdBusy, mdDone, ctl} !== 8'b0) begin
            fails++;
            $display("FAIL md_idle got %b want 0", {mdBusy, mdDone, ctl});
        end
    endtask

    task automatic test_reset_mid;
        logic seen = 1'b0;
        clr();
        @(posedge clk);
        #1 mdStartE = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        tests++;
        if (mdBusy !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_busy got %b want 1", mdBusy);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({mdBusy, stallE, flushM} !== 3'b000) begin
            fails++;
            $display("FAIL rst_async_drop got %b want 000", {mdBusy, stallE, flushM});
        end
        mdStartE = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #2;
            seen = seen | mdDone | mdBusy;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL rst_no_done got %b want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_md();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core.
- Generates the EX-stage forwarding selects (forwardAE/forwardBE) and the decode-stage branch-compare forwards.
- Detects load-use and branch-operand hazards.
- Sequences multi-cycle multiply/divide ops in EX with an internal state machine that holds F/D/E and bubbles M until the op completes.

Parameters:
- MD_LATENCY, 32, total stall cycles a mult/div op holds EX (legal range >= 2).
- CNT_W, 6, width of the MD cycle counter (must satisfy 2^CNT_W > MD_LATENCY).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- rsD  in  5  decode-stage source register 1.
- rtD  in  5  decode-stage source register 2.
- rsE  in  5  execute-stage source register 1.
- rtE  in  5  execute-stage source register 2.
- writeRegAddrE  in  5  destination register of the EX instruction.
- writeRegAddrM  in  5  destination register of the MEM instruction.
- writeRegAddrW  in  5  destination register of the WB instruction.
- regWriteE  in  1  EX instruction writes the register file.
- regWriteM  in  1  MEM instruction writes the register file.
- regWriteW  in  1  WB instruction writes the register file.
- memToRegE  in  1  EX instruction is a load.
- memToRegM  in  1  MEM instruction is a load.
- branchD  in  1  decode instruction is a branch or jr that compares/reads in D.
- branchTakenD  in  1  decode redirect is taken.
- mdStartE  in  1  EX instruction is a multi-cycle mult/div.
- forwardAE  out  2  SrcA select: 00 register file, 01 aluOutM, 10 wbOut.
- forwardBE  out  2  SrcB select, same encoding as forwardAE.
- forwardAD  out  1  forward aluOutM to D compare operand A.
- forwardBD  out  1  forward aluOutM to D compare operand B.
- stallF  out  1  hold PC.
- stallD  out  1  hold IF/ID register.
- stallE  out  1  hold ID/EX register.
- flushD  out  1  clear IF/ID register.
- flushE  out  1  clear ID/EX register.
- flushM  out  1  clear EX/MEM register (bubble).
- mdBusy  out  1  MD op occupying EX.
- mdDone  out  1  one-cycle pulse: MD result valid in EX this cycle.

Behaviour:
Forwarding (combinational):
- matchM(r) = regWriteM & writeRegAddrM!=0 & writeRegAddrM==r; matchW(r) is the same using the W-stage signals.
- forwardAE = matchM(rsE) ? 01 : matchW(rsE) ? 10 : 00. M has priority over W. forwardBE uses rtE identically.
- Register $0 is never forwarded.
- forwardAD = matchM(rsD); forwardBD = matchM(rtD).

Hazards (combinational):
- lwStall = memToRegE & regWriteE & writeRegAddrE!=0 & (writeRegAddrE==rsD | writeRegAddrE==rtD).
- brStall = branchD & ((regWriteE & writeRegAddrE!=0 & writeRegAddrE matches rsD/rtD) | (memToRegM & writeRegAddrM!=0 & writeRegAddrM matches rsD/rtD)).

MD state machine (registered state plus a CNT_W-bit counter cnt):
- States are IDLE, RUN, DONE.
- IDLE: if mdStartE, then mdStall=1 this cycle, next state RUN, cnt <= MD_LATENCY-1.
- RUN: mdStall=1, cnt <= cnt-1; when cnt==1, next state DONE.
- DONE: mdStall=0, mdDone=1, the op advances to M at the clock edge, next state IDLE. mdStartE is ignored in DONE because the same instruction is still in E.
- Total MD stall cycles = MD_LATENCY exactly.
- mdBusy = mdStall.

Output composition:
- mdStall active: stallF=stallD=stallE=1, flushM=1, flushE=0, flushD=0. lwStall and brStall are masked.
- Otherwise:
  - stallF = stallD = lwStall|brStall; flushE = lwStall|brStall; stallE=0; flushM=0.
  - flushD = branchTakenD & ~stallD.
- Back-to-back MD ops: the second op is seen in IDLE on the cycle after DONE and starts a fresh sequence.

Reset:
- rst asynchronously forces IDLE and cnt=0, so mdBusy=0, mdDone=0 and all MD-driven stalls/flushes drop immediately.
- Reset mid-RUN abandons the op with no mdDone.
- Combinational outputs follow their inputs during reset.

Test Plan:
- Forward priority: regWriteM=1, writeRegAddrM=5, regWriteW=1, writeRegAddrW=5, rsE=5, rtE=5 -> forwardAE=01, forwardBE=01. Clear regWriteM -> forwardAE=10, forwardBE=10. Set all addresses to 0 -> forwardAE=00, forwardBE=00.
- Load-use: memToRegE=1, regWriteE=1, writeRegAddrE=8, rtD=8 -> stallF=stallD=flushE=1, stallE=0; same with writeRegAddrE=0 -> no stall.
- Branch hazard: branchD=1, rsD=3, memToRegM=1, writeRegAddrM=3 -> stallD=1; also set branchTakenD=1 -> flushD=0. With memToRegM=0 and regWriteM=1 -> forwardAD=1, no stall, flushD=1.
- MD sequence, MD_LATENCY=4: pulse mdStartE high, held while stalled -> stallE=flushM=1 for exactly 4 cycles, mdDone=1 on cycle 5, stallE=0, state back to IDLE on cycle 6. Second mdStartE on cycle 6 restarts the sequence.
- MD masks load-use: during RUN drive lwStall conditions -> flushE stays 0, stallE=1.
- Reset mid-op: assert rst at RUN cnt=2 -> mdBusy, stallE and flushM drop within the same cycle (asynchronously); no mdDone follows.
